alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller for an external 8-bit ALU.
//   clk, reset        : clock, synchronous active-high reset
//   start / done      : launch program at pc=0 from IDLE or HALT / high in HALT
//   instr_*           : instruction fetch handshake (req held until vld)
//   mem_*             : data memory handshake (req held until ack)
//   alu_cmd..sc_in    : registered ALU operand drive, valid during EXEC
//   rslt..lessthan    : ALU results, sampled in EXEC
// Each instruction is FETCH -> DECODE -> EXEC (3 cycles with zero-wait fetch);
// cmd 010 adds a MEM phase that lasts until mem_ack.
// Opcode map (ir[8:6]): 000/101 reg op, 100 half-set (4-bit immediate in
// ir[5:2], register R[ir[1:0]]), 001 shift/inc/dec group, 010 load/store
// (ir[5]=1 store), 011 branch-if-notequal, 110 branch-if-lessthan,
// 111 no-op, with 9'h1FF meaning halt.
module alu_sequencer #(
  parameter logic [9:0] LUT0 = 10'd0,
  parameter logic [9:0] LUT1 = 10'd0,
  parameter logic [9:0] LUT2 = 10'd0,
  parameter logic [9:0] LUT3 = 10'd0,
  parameter logic [9:0] LUT4 = 10'd0,
  parameter logic [9:0] LUT5 = 10'd0,
  parameter logic [9:0] LUT6 = 10'd0,
  parameter logic [9:0] LUT7 = 10'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       instr_req,
  output logic [9:0] instr_addr,
  input  logic       instr_vld,
  input  logic [8:0] instr,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [2:0] alu_cmd,
  output logic [2:0] typeselect,
  output logic [3:0] immed,
  output logic [7:0] inA,
  output logic [7:0] inB,
  output logic       sc_in,
  input  logic [7:0] rslt,
  input  logic       sc_o,
  input  logic       notequal,
  input  logic       lessthan
);

  localparam logic [2:0] CMD_SHIFT = 3'b001;
  localparam logic [2:0] CMD_MEM   = 3'b010;
  localparam logic [2:0] CMD_BNE   = 3'b011;
  localparam logic [2:0] CMD_HSET  = 3'b100;
  localparam logic [2:0] CMD_BLT   = 3'b110;
  localparam logic [2:0] CMD_SYS   = 3'b111;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT} state_t;

  state_t          state, state_nxt;
  logic [7:0][7:0] rf;
  logic [9:0]      pc;
  logic            sc;
  logic [8:0]      ir;
  logic [2:0]      dst;     // write-back index, latched with the operands
  logic [2:0]      a_idx;
  logic [9:0]      lut_tgt;
  logic [9:0]      pc_inc;
  logic [2:0]      cmd;

  assign cmd    = ir[8:6];
  assign pc_inc = pc + 10'd1;   // natural 10-bit wrap 3FF -> 000

  assign done       = (state == HALT);
  assign instr_req  = (state == FETCH);
  assign instr_addr = pc;
  assign mem_req    = (state == MEM);
  assign mem_we     = (state == MEM) & ir[5];

  // Operand A source: branches compare R[ir[5:3]], half-set only reaches R0..R3.
  always_comb begin
    a_idx = ir[2:0];
    case (cmd)
      CMD_BNE, CMD_BLT: a_idx = ir[5:3];
      CMD_HSET:         a_idx = {1'b0, ir[1:0]};
      default:          a_idx = ir[2:0];
    endcase
  end

  always_comb begin
    case (ir[2:0])
      3'd0:    lut_tgt = LUT0;
      3'd1:    lut_tgt = LUT1;
      3'd2:    lut_tgt = LUT2;
      3'd3:    lut_tgt = LUT3;
      3'd4:    lut_tgt = LUT4;
      3'd5:    lut_tgt = LUT5;
      3'd6:    lut_tgt = LUT6;
      default: lut_tgt = LUT7;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALT: if (start) state_nxt = FETCH;
      FETCH:      if (instr_vld) state_nxt = DECODE;
      DECODE:     state_nxt = EXEC;
      EXEC: begin
        if (cmd == CMD_MEM)     state_nxt = MEM;
        else if (ir == 9'h1FF)  state_nxt = HALT;
        else                    state_nxt = FETCH;
      end
      MEM:        if (mem_ack) state_nxt = FETCH;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf         <= '0;
      pc         <= '0;
      sc         <= 1'b0;
      ir         <= '0;
      dst        <= '0;
      alu_cmd    <= '0;
      typeselect <= '0;
      immed      <= '0;
      inA        <= '0;
      inB        <= '0;
      sc_in      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE, HALT: if (start) pc <= '0;
        FETCH:      if (instr_vld) ir <= instr;
        DECODE: begin
          alu_cmd    <= cmd;
          typeselect <= ir[5:3];
          immed      <= ir[5:2];
          inA        <= rf[a_idx];
          inB        <= rf[0];
          sc_in      <= sc;
          dst        <= a_idx;
        end
        EXEC: begin
          case (cmd)
            CMD_SHIFT: begin
              rf[dst] <= rslt;
              // inc/dec (typeselect 11x) must not disturb the carry
              if (typeselect[2:1] != 2'b11) sc <= sc_o;
              pc <= pc_inc;
            end
            CMD_BNE: pc <= notequal ? lut_tgt : pc_inc;
            CMD_BLT: pc <= lessthan ? lut_tgt : pc_inc;
            CMD_MEM: begin
              mem_addr  <= rf[0];
              mem_wdata <= rf[ir[2:0]];
            end
            CMD_SYS: if (ir != 9'h1FF) pc <= pc_inc;
            default: begin
              rf[dst] <= rslt;
              pc      <= pc_inc;
            end
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            if (!ir[5]) rf[ir[2:0]] <= mem_rdata;
            pc <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: the bench plays instruction memory,
// data memory and ALU, and tracks architectural state in a behavioural model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, done;
  logic       instr_req, instr_vld;
  logic [9:0] instr_addr;
  logic [8:0] instr;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0] alu_cmd, typeselect;
  logic [3:0] immed;
  logic [7:0] inA, inB, rslt;
  logic       sc_in, sc_o, notequal, lessthan;

  always #5 clk = ~clk;

  alu_sequencer #(
    .LUT0(10'h123), .LUT1(10'h2A5), .LUT2(10'h00F), .LUT3(10'h040),
    .LUT4(10'h3C0), .LUT5(10'h155), .LUT6(10'h0AA), .LUT7(10'h3FF)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_vld(instr_vld), .instr(instr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_cmd(alu_cmd), .typeselect(typeselect), .immed(immed), .inA(inA), .inB(inB),
    .sc_in(sc_in), .rslt(rslt), .sc_o(sc_o), .notequal(notequal), .lessthan(lessthan)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  logic [7:0] m_rf [8];
  logic [9:0] m_pc;
  logic       m_sc;
  logic [9:0] lut [8] = '{10'h123, 10'h2A5, 10'h00F, 10'h040, 10'h3C0, 10'h155, 10'h0AA, 10'h3FF};

  // expected observations for the last step
  logic [9:0] e_addr;
  logic [2:0] e_cmd, e_ts;
  logic [3:0] e_imm;
  logic [7:0] e_a, e_b, e_maddr, e_mwd;
  logic       e_scin, e_mwe, e_halt;

  // observed values for the last step
  logic [9:0] o_addr;
  logic [2:0] o_cmd, o_ts;
  logic [3:0] o_imm;
  logic [7:0] o_a, o_b, o_maddr, o_mwd;
  logic       o_scin, o_mwe, o_mem, o_stable, o_next_req, o_done;
  int         o_mcycles, o_writes;
  logic       noise = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_pc = '0;
    m_sc = 1'b0;
  endtask

  task automatic model_step(input logic [8:0] ins, input logic [7:0] r, input logic so,
                            input logic ne, input logic lt, input logic [7:0] rd);
    logic [2:0] c;
    c       = ins[8:6];
    e_addr  = m_pc;
    e_cmd   = c;
    e_ts    = ins[5:3];
    e_imm   = ins[5:2];
    e_b     = m_rf[0];
    e_scin  = m_sc;
    e_a     = (c == 3'b011 || c == 3'b110) ? m_rf[ins[5:3]] :
              (c == 3'b100) ? m_rf[{1'b0, ins[1:0]}] : m_rf[ins[2:0]];
    e_maddr = m_rf[0];
    e_mwd   = m_rf[ins[2:0]];
    e_mwe   = ins[5];
    e_halt  = (ins == 9'h1FF);
    case (c)
      3'b011: m_pc = ne ? lut[ins[2:0]] : m_pc + 10'd1;
      3'b110: m_pc = lt ? lut[ins[2:0]] : m_pc + 10'd1;
      3'b010: begin if (!ins[5]) m_rf[ins[2:0]] = rd; m_pc = m_pc + 10'd1; end
      3'b111: if (!e_halt) m_pc = m_pc + 10'd1;
      3'b001: begin
        m_rf[ins[2:0]] = r;
        if (ins[5:4] != 2'b11) m_sc = so;
        m_pc = m_pc + 10'd1;
      end
      3'b100: begin m_rf[ins[1:0]] = r; m_pc = m_pc + 10'd1; end
      default: begin m_rf[ins[2:0]] = r; m_pc = m_pc + 10'd1; end
    endcase
  endtask

  // Drives one instruction through the DUT and records what it showed.
  // dly = cycles before mem_ack; dly < 0 leaves the DUT parked in MEM.
  task automatic exec_instr(input logic [8:0] ins, input logic [7:0] r, input logic so,
                            input logic ne, input logic lt, input int dly, input logic [7:0] rd);
    int n;
    rslt = r; sc_o = so; notequal = ne; lessthan = lt; mem_rdata = rd;
    o_mcycles = 0; o_writes = 0; o_stable = 1'b1; o_mem = 1'b0;
    n = 0;
    while (!instr_req && n < 20) begin @(negedge clk); n++; end
    if (!instr_req) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: instr_req=%b, required 1", instr_req);
      return;
    end
    o_addr = instr_addr;
    instr = ins; instr_vld = 1'b1;
    @(negedge clk);
    instr_vld = 1'b0;
    if (noise) begin start = 1'b1; instr_vld = 1'b1; instr = ~ins; end
    @(negedge clk);
    start = 1'b0; instr_vld = 1'b0;
    o_cmd = alu_cmd; o_ts = typeselect; o_imm = immed;
    o_a = inA; o_b = inB; o_scin = sc_in;
    @(negedge clk);
    o_next_req = instr_req; o_done = done;
    if (mem_req) begin
      o_mem = 1'b1; o_maddr = mem_addr; o_mwd = mem_wdata; o_mwe = mem_we;
      n = 0;
      forever begin
        o_mcycles++;
        if (mem_addr !== o_maddr || mem_wdata !== o_mwd || mem_we !== o_mwe || !mem_req)
          o_stable = 1'b0;
        if (dly < 0 && n == 2) break;
        if (n == dly || n >= 40) begin
          mem_ack = 1'b1;
          if (mem_req && mem_we) o_writes++;
          @(negedge clk);
          mem_ack = 1'b0;
          break;
        end
        @(negedge clk); n++;
      end
      o_next_req = instr_req;
    end
  endtask

  task automatic step(input logic [8:0] ins, input logic [7:0] r, input logic so,
                      input logic ne, input logic lt, input int dly, input logic [7:0] rd);
    exec_instr(ins, r, so, ne, lt, dly, rd);
    model_step(ins, r, so, ne, lt, rd);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    m_pc = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({done, instr_req, mem_req, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: done/ireq/mreq/we=%b, required 0000", {done, instr_req, mem_req, mem_we});
    end
    checks++;
    if ({alu_cmd, typeselect, immed, inA, inB, sc_in} !== '0) begin
      errors++; $display("FAIL reset_alu: got %h, required 0", {alu_cmd, typeselect, immed, inA, inB, sc_in});
    end
    checks++;
    if (instr_addr !== 10'h000) begin
      errors++; $display("FAIL reset_pc: got %h, required 000", instr_addr);
    end
    pulse_start();
  endtask

  task automatic test_inc();
    step(9'b000_000_001, 8'h01, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    step(9'b001_111_001, 8'h02, 1'b1, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_a !== 8'h01 || o_cmd !== 3'b001 || o_ts !== 3'b111) begin
      errors++; $display("FAIL inc_drive: inA=%h cmd=%b ts=%b, required 01 001 111", o_a, o_cmd, o_ts);
    end
    checks++;
    if (o_next_req !== 1'b1) begin
      errors++; $display("FAIL inc_3cycle: instr_req=%b, required 1", o_next_req);
    end
    step(9'b010_1_00_001, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_mwd !== 8'h02) begin
      errors++; $display("FAIL inc_result: R1=%h, required 02", o_mwd);
    end
    checks++;
    if (o_scin !== 1'b0) begin
      errors++; $display("FAIL inc_sc: sc=%b, required 0", o_scin);
    end
    checks++;
    if (o_addr !== e_addr) begin
      errors++; $display("FAIL inc_pc: pc=%h, required %h", o_addr, e_addr);
    end
  endtask

  task automatic test_branch();
    logic [9:0] p;
    step(9'b000_000_000, 8'h05, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    step(9'b000_000_010, 8'h05, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    step(9'b011_010_011, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    p = o_addr;
    checks++;
    if (o_a !== 8'h05 || o_b !== 8'h05) begin
      errors++; $display("FAIL bne_ops: inA=%h inB=%h, required 05 05", o_a, o_b);
    end
    step(9'b111_000_000, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_addr !== p + 10'd1) begin
      errors++; $display("FAIL bne_fallthru: pc=%h, required %h", o_addr, p + 10'd1);
    end
    step(9'b011_010_011, 8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00);
    step(9'b111_000_000, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_addr !== 10'h040) begin
      errors++; $display("FAIL bne_taken: pc=%h, required 040", o_addr);
    end
    step(9'b110_001_101, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h00);
    step(9'b111_000_000, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_addr !== 10'h155) begin
      errors++; $display("FAIL blt_taken: pc=%h, required 155", o_addr);
    end
  endtask

  task automatic test_store();
    step(9'b000_000_000, 8'h10, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    step(9'b000_000_100, 8'hAA, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    step(9'b010_1_00_100, 8'h00, 1'b0, 1'b0, 1'b0, 3, 8'h00);
    checks++;
    if (o_maddr !== 8'h10 || o_mwd !== 8'hAA || o_mwe !== 1'b1) begin
      errors++; $display("FAIL store_bus: addr=%h wdata=%h we=%b, required 10 AA 1", o_maddr, o_mwd, o_mwe);
    end
    checks++;
    if (o_mcycles != 4 || o_stable !== 1'b1) begin
      errors++; $display("FAIL store_hold: cycles=%0d stable=%b, required 4 1", o_mcycles, o_stable);
    end
    checks++;
    if (o_writes != 1) begin
      errors++; $display("FAIL store_count: writes=%0d, required 1", o_writes);
    end
    step(9'b010_0_00_110, 8'h00, 1'b0, 1'b0, 1'b0, 1, 8'h5C);
    step(9'b010_1_00_110, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_mwd !== 8'h5C) begin
      errors++; $display("FAIL load_data: R6=%h, required 5C", o_mwd);
    end
  endtask

  task automatic test_start_ignored();
    logic [9:0] p;
    noise = 1'b1;
    step(9'b111_000_001, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    noise = 1'b0;
    p = o_addr;
    checks++;
    if (o_cmd !== 3'b111 || o_imm !== 4'b0000) begin
      errors++; $display("FAIL vld_ignored: cmd=%b imm=%b, required 111 0000", o_cmd, o_imm);
    end
    step(9'b111_000_000, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_addr !== p + 10'd1) begin
      errors++; $display("FAIL start_ignored: pc=%h, required %h", o_addr, p + 10'd1);
    end
  endtask

  task automatic test_halt();
    logic bad;
    step(9'h1FF, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_done !== 1'b1 || o_next_req !== 1'b0) begin
      errors++; $display("FAIL halt_enter: done=%b instr_req=%b, required 1 0", o_done, o_next_req);
    end
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (instr_req !== 1'b0 || done !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL halt_hold: instr_req/done not 0/1 while halted, required 0/1");
    end
    pulse_start();
    step(9'b010_1_00_100, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_addr !== 10'h000 || o_mwd !== 8'hAA) begin
      errors++; $display("FAIL halt_restart: pc=%h R4=%h, required 000 AA", o_addr, o_mwd);
    end
  endtask

  task automatic test_shift_wrap();
    step(9'b001_100_000, 8'h01, 1'b1, 1'b0, 1'b0, 0, 8'h00);
    step(9'b001_100_000, 8'h02, 1'b1, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_scin !== 1'b1) begin
      errors++; $display("FAIL shift_carry: sc_in=%b, required 1", o_scin);
    end
    step(9'b001_110_000, 8'h03, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    step(9'b111_000_000, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_scin !== 1'b1) begin
      errors++; $display("FAIL incdec_sc: sc_in=%b, required 1", o_scin);
    end
    step(9'b011_000_111, 8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00);
    step(9'b001_100_000, 8'h04, 1'b1, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_addr !== 10'h3FF) begin
      errors++; $display("FAIL wrap_pre: pc=%h, required 3FF", o_addr);
    end
    step(9'b111_000_000, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_addr !== 10'h000) begin
      errors++; $display("FAIL wrap_post: pc=%h, required 000", o_addr);
    end
  endtask

  task automatic test_reset_in_mem();
    step(9'b000_000_011, 8'h21, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    exec_instr(9'b010_0_00_011, 8'h00, 1'b0, 1'b0, 1'b0, -1, 8'h77);
    reset = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || instr_req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mem: mreq=%b ireq=%b done=%b, required 0 0 0", mem_req, instr_req, done);
    end
    reset = 1'b0; mem_ack = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (instr_req !== 1'b0) begin
      errors++; $display("FAIL rst_idle: instr_req=%b, required 0", instr_req);
    end
    pulse_start();
    step(9'b010_1_00_011, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checks++;
    if (o_addr !== 10'h000 || o_mwd === 8'h77) begin
      errors++; $display("FAIL rst_nowrite: pc=%h R3=%h, required 000 and not 77", o_addr, o_mwd);
    end
  endtask

  task automatic test_random();
    logic [8:0] ins;
    int dly;
    for (int k = 0; k < 80; k++) begin
      ins = 9'($urandom);
      if (ins == 9'h1FF) ins = 9'h1FE;
      dly = int'($urandom_range(0, 3));
      noise = ($urandom_range(0, 7) == 0);
      step(ins, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), dly, 8'($urandom));
      noise = 1'b0;
      checks++;
      if (o_addr !== e_addr) begin
        errors++; $display("FAIL rnd_pc[%0d]: got %h, required %h", k, o_addr, e_addr);
      end
      checks++;
      if ({o_cmd, o_ts, o_imm, o_scin} !== {e_cmd, e_ts, e_imm, e_scin}) begin
        errors++; $display("FAIL rnd_ctl[%0d] ins=%h: got %h, required %h", k, ins,
                           {o_cmd, o_ts, o_imm, o_scin}, {e_cmd, e_ts, e_imm, e_scin});
      end
      checks++;
      if (o_a !== e_a || o_b !== e_b) begin
        errors++; $display("FAIL rnd_ops[%0d] ins=%h: inA=%h inB=%h, required %h %h", k, ins, o_a, o_b, e_a, e_b);
      end
      checks++;
      if (o_mem !== (ins[8:6] == 3'b010)) begin
        errors++; $display("FAIL rnd_memphase[%0d]: mem=%b, required %b", k, o_mem, ins[8:6] == 3'b010);
      end
      if (o_mem) begin
        checks++;
        if (o_maddr !== e_maddr || o_mwd !== e_mwd || o_mwe !== e_mwe ||
            o_mcycles != dly + 1 || o_stable !== 1'b1) begin
          errors++; $display("FAIL rnd_mem[%0d]: addr=%h wd=%h we=%b cyc=%0d st=%b, required %h %h %b %0d 1",
                             k, o_maddr, o_mwd, o_mwe, o_mcycles, o_stable, e_maddr, e_mwd, e_mwe, dly + 1);
        end
      end
      checks++;
      if (o_next_req !== 1'b1) begin
        errors++; $display("FAIL rnd_refetch[%0d]: instr_req=%b, required 1", k, o_next_req);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr_vld = 1'b0; instr = '0;
    mem_ack = 1'b0; mem_rdata = '0; rslt = '0; sc_o = 1'b0; notequal = 1'b0; lessthan = 1'b0;
    model_reset();
    test_reset();
    test_inc();
    test_branch();
    test_store();
    test_start_ignored();
    test_halt();
    test_shift_wrap();
    test_reset_in_mem();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
